// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone instruction/data arbiter.
// Holds the FSM state encoding and the default bus-timeout length.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_bus_watchdog.sv
// Bus-timeout watchdog: counts granted cycles without an acknowledge and
// flags expiry once the count reaches TIMEOUT_CYCLES (0 disables it).
module wb_bus_watchdog
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expire
);

    localparam int unsigned    CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Saturates at LIMIT so a stuck count can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (active && !ack && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An acknowledge arriving on the limit cycle takes precedence.
    assign expire = (TIMEOUT_CYCLES != 0) && active && !ack && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_instr_data_arbiter.sv
// Round-robin arbiter merging the instruction (s0) and data (s1) Wishbone
// classic masters onto one slave port, with a bus-timeout watchdog.
module wb_instr_data_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    s0_cyc,
    input  logic                    s0_stb,
    input  logic                    s0_we,
    input  logic [DATA_WIDTH/8-1:0] s0_sel,
    input  logic [ADDR_WIDTH-1:0]   s0_adr,
    input  logic [DATA_WIDTH-1:0]   s0_dat_w,
    output logic [DATA_WIDTH-1:0]   s0_dat_r,
    output logic                    s0_ack,
    output logic                    s0_err,

    input  logic                    s1_cyc,
    input  logic                    s1_stb,
    input  logic                    s1_we,
    input  logic [DATA_WIDTH/8-1:0] s1_sel,
    input  logic [ADDR_WIDTH-1:0]   s1_adr,
    input  logic [DATA_WIDTH-1:0]   s1_dat_w,
    output logic [DATA_WIDTH-1:0]   s1_dat_r,
    output logic                    s1_ack,
    output logic                    s1_err,

    output logic                    m_cyc,
    output logic                    m_stb,
    output logic                    m_we,
    output logic [DATA_WIDTH/8-1:0] m_sel,
    output logic [ADDR_WIDTH-1:0]   m_adr,
    output logic [DATA_WIDTH-1:0]   m_dat_w,
    input  logic [DATA_WIDTH-1:0]   m_dat_r,
    input  logic                    m_ack
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

    arb_state_e state_q, state_d;
    logic       last_q, last_d;

    logic req0, req1;
    logic granted, own0, own1;
    logic start, expire;

    logic                  cur_cyc, cur_stb, cur_we;
    logic [SEL_WIDTH-1:0]  cur_sel;
    logic [ADDR_WIDTH-1:0] cur_adr;
    logic [DATA_WIDTH-1:0] cur_dat_w;

    assign req0    = s0_cyc & s0_stb;
    assign req1    = s1_cyc & s1_stb;
    assign own0    = (state_q == GNT0);
    assign own1    = (state_q == GNT1);
    assign granted = own0 | own1;

    // Request fields of whichever master currently owns the bus.
    assign cur_cyc   = own1 ? s1_cyc   : s0_cyc;
    assign cur_stb   = own1 ? s1_stb   : s0_stb;
    assign cur_we    = own1 ? s1_we    : s0_we;
    assign cur_sel   = own1 ? s1_sel   : s0_sel;
    assign cur_adr   = own1 ? s1_adr   : s0_adr;
    assign cur_dat_w = own1 ? s1_dat_w : s0_dat_w;

    assign start = (state_q == IDLE) && (state_d != IDLE);

    wb_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .active(granted),
        .ack   (m_ack),
        .expire(expire)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // On contention the master not served last wins.
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (m_ack) begin
                    state_d = IDLE;
                    last_d  = own1;
                end else if (!cur_cyc) begin
                    state_d = IDLE;
                end else if (expire) begin
                    state_d = IDLE;
                    last_d  = own1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign m_cyc   = granted & cur_cyc & ~expire;
    assign m_stb   = granted & cur_cyc & cur_stb & ~expire;
    assign m_we    = granted & cur_we;
    assign m_sel   = granted ? cur_sel   : '0;
    assign m_adr   = granted ? cur_adr   : '0;
    assign m_dat_w = granted ? cur_dat_w : '0;

    assign s0_ack = own0 & m_ack;
    assign s1_ack = own1 & m_ack;
    assign s0_err = own0 & cur_cyc & expire;
    assign s1_err = own1 & cur_cyc & expire;

    assign s0_dat_r = m_dat_r;
    assign s1_dat_r = m_dat_r;

endmodule
